// File: rtl/mac_pkg.sv
// Shared types and constants for the signed 8-bit dot-product sequencer.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int ACC_W_DEF = 16;
  localparam int LEN_W_DEF = 8;
  localparam int DRAIN_LEN = 2;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Job, operand-stream and result handshakes of mac_sequencer.
interface mac_sequencer_if #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
);
  logic                    START;
  logic [LEN_W-1:0]        LEN;
  logic                    BUSY;
  logic signed [7:0]       A_IN;
  logic signed [7:0]       B_IN;
  logic                    IN_VALID;
  logic                    IN_READY;
  logic signed [ACC_W-1:0] O;
  logic                    O_VALID;
  logic                    O_READY;
  logic                    OVF;

  modport master (
    output START, LEN, A_IN, B_IN, IN_VALID, O_READY,
    input  BUSY, IN_READY, O, O_VALID, OVF
  );

  modport slave (
    input  START, LEN, A_IN, B_IN, IN_VALID, O_READY,
    output BUSY, IN_READY, O, O_VALID, OVF
  );
endinterface

// File: rtl/mac_datapath.sv
// Operand register -> signed multiplier -> saturating accumulator, with a
// valid bit riding along each stage so bubbles add nothing.
module mac_datapath
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    fire_i,
  input  logic signed [7:0]       a_i,
  input  logic signed [7:0]       b_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    ovf_o
);
  localparam int STAGES = 2;
  localparam logic signed [63:0] MAX64 = sat_max(ACC_W);
  localparam logic signed [63:0] MIN64 = sat_min(ACC_W);
  localparam logic signed [ACC_W:0] MAXV = MAX64[ACC_W:0];
  localparam logic signed [ACC_W:0] MINV = MIN64[ACC_W:0];

  logic [STAGES:1]         vld_pipe;
  logic signed [7:0]       a_q, b_q;
  logic signed [15:0]      prod_q, mul;
  logic signed [ACC_W-1:0] acc_q;
  logic                    ovf_q;
  logic signed [ACC_W:0]   sum;

  assign mul = a_q * b_q;
  // One guard bit is enough: |product| <= 2^14 and the accumulator is clamped.
  assign sum = $signed({acc_q[ACC_W-1], acc_q})
             + $signed({{(ACC_W+1-16){prod_q[15]}}, prod_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], fire_i};
      if (fire_i) begin
        a_q <= a_i;
        b_q <= b_i;
      end
      if (vld_pipe[1]) prod_q <= mul;
      if (clr_i) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (vld_pipe[2]) begin
        if (sum > MAXV) begin
          acc_q <= MAXV[ACC_W-1:0];
          ovf_q <= 1'b1;
        end else if (sum < MINV) begin
          acc_q <= MINV[ACC_W-1:0];
          ovf_q <= 1'b1;
        end else begin
          acc_q <= sum[ACC_W-1:0];
        end
      end
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/mac_sequencer.sv
// Job FSM, pair/drain counters and handshakes around mac_datapath.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic          CLK,
  input  logic          RESETN,
  mac_sequencer_if.slave bus
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic             busy_q, in_ready_q, o_valid_q;
  logic             clr, fire;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      o_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      busy_q     <= (state_d != IDLE);
      in_ready_q <= (state_d == RUN);
      // Result becomes visible one cycle after DONE is entered, once the
      // accumulator has settled; it drops on the consuming handshake.
      o_valid_q  <= (state_q == DONE) && (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    clr     = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          clr = 1'b1;
          if (bus.LEN != '0) begin
            cnt_d   = bus.LEN;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        fire = bus.IN_VALID && in_ready_q;
        if (fire) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            state_d = DRAIN;
            dcnt_d  = 2'(DRAIN_LEN - 1);
          end
        end
      end
      DRAIN: begin
        if (dcnt_q == '0) state_d = DONE;
        else              dcnt_d  = dcnt_q - 1'b1;
      end
      DONE: begin
        if (o_valid_q && bus.O_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  mac_datapath #(.ACC_W(ACC_W)) u_dp (
    .clk    (CLK),
    .rst_n  (RESETN),
    .clr_i  (clr),
    .fire_i (fire),
    .a_i    (bus.A_IN),
    .b_i    (bus.B_IN),
    .acc_o  (bus.O),
    .ovf_o  (bus.OVF)
  );

  assign bus.BUSY     = busy_q;
  assign bus.IN_READY = in_ready_q;
  assign bus.O_VALID  = o_valid_q;
endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Single-clock controller and pipelined datapath for signed 8-bit dot products. It accepts a job length on `START`, pulls that many operand pairs over a valid/ready stream, and runs them through operand register → multiplier → saturating accumulator. It then presents the accumulated result on a valid/ready output. It replaces the free-running two-clock multiply-accumulate chain with a sequenced, back-pressurable one.

## Interface
Parameters:
- `ACC_W`, 16: accumulator/result width, ≥ 16.
- `LEN_W`, 8: job length width; maximum job length is 2^LEN_W−1.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RESETN` in 1: one clock; reset is asynchronous and active-low.
- `START` in 1: job request, sampled only in IDLE.
- `LEN` in `LEN_W`: number of operand pairs, captured with `START`.
- `BUSY` out 1: high in every state except IDLE.
- `A_IN`, `B_IN` in 8 each: signed two's-complement operands.
- `IN_VALID` in 1: operand pair valid.
- `IN_READY` out 1: sequencer accepts a pair.
- `O` out `ACC_W`: signed result.
- `O_VALID` out 1: result valid.
- `O_READY` in 1: consumer takes the result.
- `OVF` out 1: sticky saturation flag for the current/last job.

## Operation
- States are IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `START`=1 and `LEN`≠0: capture `LEN` into the remaining counter, clear the accumulator, clear `OVF`, go to RUN.
  - `START`=1 and `LEN`=0: clear the accumulator, clear `OVF`, go directly to DONE. The result is 0.
- RUN:
  - `IN_READY`=1.
  - On `IN_VALID`&&`IN_READY`: latch A/B into the operand registers and decrement the counter.
  - When the counter goes from 1 to 0 on an accept, go to DRAIN.
  - `IN_VALID` low stalls the job indefinitely; the pipeline keeps draining.
- DRAIN:
  - `IN_READY`=0.
  - Wait 2 cycles for the last product to reach the accumulator, then go to DONE.
- DONE:
  - `O_VALID`=1. `O` and `OVF` are held stable.
  - On `O_READY`=1, go to IDLE.
  - `O` keeps its last value in IDLE until the next `START`.
- `START` outside IDLE is ignored. No queuing.
- Datapath, per valid pipeline slot:
  - Product = A×B, signed, 16 bits. It is exact, range −16256..16384.
  - Sign-extend the product to `ACC_W`+1 bits and add it to the accumulator.
  - If the sum exceeds 2^(`ACC_W`−1)−1, clamp to that value and set `OVF`.
  - If the sum is below −2^(`ACC_W`−1), clamp to that value and set `OVF`.
  - `OVF` stays set until the next accepted `START`.
- Valid bits travel with the operand and product stages. Bubbles add 0 and are not counted.

## Timing
- Reset values: state IDLE, `BUSY`=0, `IN_READY`=0, `O`=0, `O_VALID`=0, `OVF`=0. All counters, pipeline registers and valid bits are 0.
- `START` accepted at edge s: `BUSY`=1 and `IN_READY`=1 after s.
- Each accepted pair follows a fixed schedule:
  - Accepted at edge e0.
  - Product registered at e1.
  - Accumulated at e2.
- Throughput is one pair per cycle when `IN_VALID` is held high.
- Last pair accepted at edge e0: `O_VALID` rises after e3. That is 3 cycles of latency, 2 of them in DRAIN.
- `LEN`=0: `O_VALID` rises after edge s+1.
- `O_VALID`&&`O_READY` at edge d: `O_VALID` and `BUSY` fall after d. A `START` in the same cycle is not sampled; the earliest is at d+1.
- Reset asserted mid-job forces the reset values immediately (asynchronous). The job is discarded and no result is produced.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `mac_pkg` holds:
  - State enum: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - Default `ACC_W`/`LEN_W` constants.
  - Saturation limit functions `sat_max(ACC_W)`/`sat_min(ACC_W)`.
  - DRAIN length constant = 2.
- One sub-module, `mac_datapath`: operand registers, signed multiplier, product register, saturating accumulator with valid-bit pipeline, and `OVF` logic.
- `mac_sequencer` contains only the FSM, the counters and the handshakes.

## Test plan
- Reset mid-RUN:
  - Stimulus: `LEN`=4, reset after 2 accepts.
  - Required: all outputs 0 within the reset assertion; after release, a new job with `LEN`=1, A=3, B=4 gives `O`=12.
- Basic:
  - Stimulus: `LEN`=3, pairs (2,3), (−4,5), (7,−1), `IN_VALID` held high, `O_READY`=1.
  - Required: `O`=−21, `OVF`=0, `O_VALID` 3 cycles after the 3rd accept, exactly 1 cycle wide.
- Stalls and back-pressure:
  - Stimulus: same job as Basic, `IN_VALID` toggling 1,0,0,1,0,1; `O_READY` low for 5 cycles.
  - Required: `O`=−21 held stable with `O_VALID`=1 for all 5 cycles; `START` pulses during the job are ignored.
- Saturation:
  - Stimulus: `ACC_W`=16, `LEN`=3, pairs (−128,−128)×3.
  - Required: `O`=32767, `OVF`=1.
  - Follow-up: next job (−128,127)×3 gives `O`=−32768, `OVF`=1; a further job (1,1) gives `O`=1, `OVF`=0.
- Zero length:
  - Stimulus: `LEN`=0.
  - Required: `IN_READY` never rises; `O`=0 with `O_VALID`=1 one cycle after `START`.
